// File: rtl/hdmi_pkg.sv
// Shared TMDS definitions: symbol type, the four control-period symbols and bit-count helpers.
package hdmi_pkg;

    typedef logic [9:0] tmds_symbol_t;

    localparam tmds_symbol_t TMDS_CTL_00 = 10'b1101010100;
    localparam tmds_symbol_t TMDS_CTL_01 = 10'b0010101011;
    localparam tmds_symbol_t TMDS_CTL_10 = 10'b0101010100;
    localparam tmds_symbol_t TMDS_CTL_11 = 10'b1010101011;

    function automatic logic [3:0] popcount8(input logic [7:0] value);
        logic [3:0] count;
        count = 4'd0;
        for (int i = 0; i < 8; i++) begin
            count = count + {3'b000, value[i]};
        end
        return count;
    endfunction

    function automatic tmds_symbol_t ctl_symbol(input logic [1:0] ctl_bits);
        tmds_symbol_t sym;
        case (ctl_bits)
            2'b00:   sym = TMDS_CTL_00;
            2'b01:   sym = TMDS_CTL_01;
            2'b10:   sym = TMDS_CTL_10;
            default: sym = TMDS_CTL_11;
        endcase
        return sym;
    endfunction

endpackage

// File: rtl/tmds_channel_encoder.sv
// One TMDS channel: transition-minimised, DC-balanced 8b/10b symbol every pixel clock.
// Define TMDS_ENCODER_PIPELINE_EN to register the stage-1 result (latency 2 instead of 1).
module tmds_channel_encoder
    import hdmi_pkg::*;
(
    input  logic       pixel_clk,
    input  logic       rst,
    input  logic       de,
    input  logic [7:0] data,
    input  logic [1:0] ctl,
    output logic [9:0] tmds
);

    logic [3:0] n1d;
    logic       use_xnor;
    logic [8:0] qm_s1;

    always_comb begin
        n1d      = popcount8(data);
        use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !data[0]);
        qm_s1    = '0;
        qm_s1[0] = data[0];
        for (int i = 1; i < 8; i++) begin
            qm_s1[i] = use_xnor ? ~(qm_s1[i-1] ^ data[i]) : (qm_s1[i-1] ^ data[i]);
        end
        qm_s1[8] = ~use_xnor;
    end

    logic [8:0] qm_s2;
    logic       de_s2;
    logic [1:0] ctl_s2;

`ifdef TMDS_ENCODER_PIPELINE_EN
    // de and ctl ride alongside q_m so each symbol keeps its own mode.
    logic [8:0] qm_q;
    logic       de_q;
    logic [1:0] ctl_q;

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            qm_q  <= '0;
            de_q  <= 1'b0;
            ctl_q <= 2'b00;
        end else begin
            qm_q  <= qm_s1;
            de_q  <= de;
            ctl_q <= ctl;
        end
    end

    assign qm_s2  = qm_q;
    assign de_s2  = de_q;
    assign ctl_s2 = ctl_q;
`else
    assign qm_s2  = qm_s1;
    assign de_s2  = de;
    assign ctl_s2 = ctl;
`endif

    logic [3:0]        n1q;
    logic signed [4:0] diff;
    logic signed [4:0] cnt_q;
    logic signed [4:0] cnt_d;
    tmds_symbol_t      tmds_q;
    tmds_symbol_t      tmds_d;

    always_comb begin
        n1q = popcount8(qm_s2[7:0]);
        // ones minus zeros of q_m[7:0]; modular 5-bit arithmetic lands in -8..8
        diff   = ($signed({1'b0, n1q}) <<< 1) - 5'sd8;
        tmds_d = TMDS_CTL_00;
        cnt_d  = 5'sd0;
        if (!de_s2) begin
            tmds_d = ctl_symbol(ctl_s2);
            cnt_d  = 5'sd0;
        end else if ((cnt_q == 5'sd0) || (diff == 5'sd0)) begin
            tmds_d = {~qm_s2[8], qm_s2[8], qm_s2[8] ? qm_s2[7:0] : ~qm_s2[7:0]};
            cnt_d  = qm_s2[8] ? (cnt_q + diff) : (cnt_q - diff);
        end else if (((cnt_q > 5'sd0) && (diff > 5'sd0)) ||
                     ((cnt_q < 5'sd0) && (diff < 5'sd0))) begin
            tmds_d = {1'b1, qm_s2[8], ~qm_s2[7:0]};
            cnt_d  = cnt_q + $signed({3'b000, qm_s2[8], 1'b0}) - diff;
        end else begin
            tmds_d = {1'b0, qm_s2[8], qm_s2[7:0]};
            cnt_d  = cnt_q + diff - $signed({3'b000, ~qm_s2[8], 1'b0});
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            tmds_q <= TMDS_CTL_00;
            cnt_q  <= 5'sd0;
        end else begin
            tmds_q <= tmds_d;
            cnt_q  <= cnt_d;
        end
    end

    assign tmds = tmds_q;

endmodule
